// File: rtl/cpu6502_pkg.sv
// Shared encodings for the 6502 group-01 instruction sequencer: states,
// address-select codes, addressing-mode (bbb) codes and ALU (aaa) codes.
package cpu6502_pkg;

  localparam logic [3:0] S_FETCH = 4'd0;
  localparam logic [3:0] S_IM0   = 4'd1;
  localparam logic [3:0] S_ZP0   = 4'd2;
  localparam logic [3:0] S_ZPX   = 4'd3;
  localparam logic [3:0] S_ZP1   = 4'd4;
  localparam logic [3:0] S_AB0   = 4'd5;
  localparam logic [3:0] S_AB1   = 4'd6;
  localparam logic [3:0] S_ABX   = 4'd7;
  localparam logic [3:0] S_FIX   = 4'd8;
  localparam logic [3:0] S_AB2   = 4'd9;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_ZP  = 2'b01;
  localparam logic [1:0] SEL_AB  = 2'b10;
  localparam logic [1:0] SEL_ABH = 2'b11;

  localparam logic [2:0] MODE_IMM = 3'b010;
  localparam logic [2:0] MODE_ZP  = 3'b001;
  localparam logic [2:0] MODE_ZPX = 3'b101;
  localparam logic [2:0] MODE_ABS = 3'b011;
  localparam logic [2:0] MODE_ABX = 3'b111;
  localparam logic [2:0] MODE_ABY = 3'b110;

  localparam logic [2:0] OP_ORA = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_EOR = 3'd2;
  localparam logic [2:0] OP_ADC = 3'd3;
  localparam logic [2:0] OP_STA = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_SBC = 3'd7;

endpackage

// File: rtl/control_unit_seq_if.sv
// Bus between the sequencer (master) and the instruction register / datapath
// (slave). ready: memory ready; when 0 the sequencer holds state and drops all loads.
interface control_unit_seq_if #(parameter int ALU_OP_W = 3);
  logic                ready;
  logic [7:0]          opcode;
  logic [7:0]          opcode_reg;
  logic                index_carry;
  logic                instruction_load;
  logic                increment_pc;
  logic                dirl_load;
  logic                dirh_load;
  logic                a_load;
  logic                p_load;
  logic                read_write;
  logic [1:0]          address_select;
  logic                index_en;
  logic                index_select;
  logic [ALU_OP_W-1:0] alu_opcode;

  modport master (
    input  ready, opcode, opcode_reg, index_carry,
    output instruction_load, increment_pc, dirl_load, dirh_load, a_load, p_load,
           read_write, address_select, index_en, index_select, alu_opcode
  );

  modport slave (
    output ready, opcode, opcode_reg, index_carry,
    input  instruction_load, increment_pc, dirl_load, dirh_load, a_load, p_load,
           read_write, address_select, index_en, index_select, alu_opcode
  );
endinterface

// File: rtl/cu_mode_decode.sv
// Combinational group-01 decode: addressing mode, store flag and validity.
module cu_mode_decode
  import cpu6502_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [2:0] mode,
  output logic       is_store,
  output logic       valid
);
  logic cc_ok;

  always_comb begin
    cc_ok    = (opcode[1:0] == 2'b01);
    mode     = opcode[4:2];
    is_store = cc_ok && (opcode[7:5] == OP_STA);
    // Indirect modes (bbb 000/100) and STA #imm are treated as NOPs.
    valid    = cc_ok && (mode != 3'b000) && (mode != 3'b100) && (opcode != 8'h89);
  end
endmodule

// File: rtl/control_unit_seq.sv
// 6502 group-01 instruction sequencer. Define PAGE_CROSS_OPT_EN to let an
// indexed-absolute read with no page cross complete in ABX and skip FIX.
module control_unit_seq
  import cpu6502_pkg::*;
#(
  parameter int                  ALU_OP_W   = 3,
  parameter logic [ALU_OP_W-1:0] NOP_ALU_OP = {ALU_OP_W{1'b1}},
  parameter int                  STATE_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  control_unit_seq_if.master  bus,
  output logic [STATE_W-1:0]  state_dbg
);
  logic [STATE_W-1:0] state_q, state_d;
  logic [7:0]         dec_in;
  logic [2:0]         mode;
  logic               is_store, valid, fin, fast_ok;
  logic               il, pc, dl, dh, al, pl, rw, ie, is;
  logic [1:0]         sel;

  // FETCH decodes the live bus byte; every later state decodes the latched one.
  assign dec_in = (state_q == STATE_W'(S_FETCH)) ? bus.opcode : bus.opcode_reg;

  cu_mode_decode u_dec (
    .opcode   (dec_in),
    .mode     (mode),
    .is_store (is_store),
    .valid    (valid)
  );

`ifdef PAGE_CROSS_OPT_EN
  assign fast_ok = !is_store && !bus.index_carry;
`else
  assign fast_ok = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    {il, pc, dl, dh, al, pl, rw, ie, is, fin} = '0;
    sel = SEL_PC;
    case (state_q)
      STATE_W'(S_FETCH): begin
        il = 1'b1;
        pc = 1'b1;
        if (!valid)                                    state_d = STATE_W'(S_FETCH);
        else if (mode == MODE_IMM)                     state_d = STATE_W'(S_IM0);
        else if (mode == MODE_ZP || mode == MODE_ZPX)  state_d = STATE_W'(S_ZP0);
        else                                           state_d = STATE_W'(S_AB0);
      end
      STATE_W'(S_IM0): begin
        pc      = 1'b1;
        fin     = 1'b1;
        state_d = STATE_W'(S_FETCH);
      end
      STATE_W'(S_ZP0): begin
        dl      = 1'b1;
        pc      = 1'b1;
        state_d = (mode == MODE_ZPX) ? STATE_W'(S_ZPX) : STATE_W'(S_ZP1);
      end
      STATE_W'(S_ZPX): begin
        sel     = SEL_ZP;
        ie      = 1'b1;
        state_d = STATE_W'(S_ZP1);
      end
      STATE_W'(S_ZP1): begin
        // Zero-page indexing wraps inside page 0, so index_carry is ignored.
        sel     = SEL_ZP;
        ie      = (mode == MODE_ZPX);
        fin     = 1'b1;
        state_d = STATE_W'(S_FETCH);
      end
      STATE_W'(S_AB0): begin
        dl      = 1'b1;
        pc      = 1'b1;
        state_d = STATE_W'(S_AB1);
      end
      STATE_W'(S_AB1): begin
        dh      = 1'b1;
        pc      = 1'b1;
        state_d = (mode == MODE_ABS) ? STATE_W'(S_AB2) : STATE_W'(S_ABX);
      end
      STATE_W'(S_ABX): begin
        sel     = SEL_AB;
        ie      = 1'b1;
        is      = (mode == MODE_ABY);
        fin     = fast_ok;
        state_d = fast_ok ? STATE_W'(S_FETCH) : STATE_W'(S_FIX);
      end
      STATE_W'(S_FIX): begin
        sel     = bus.index_carry ? SEL_ABH : SEL_AB;
        ie      = 1'b1;
        is      = (mode == MODE_ABY);
        fin     = 1'b1;
        state_d = STATE_W'(S_FETCH);
      end
      STATE_W'(S_AB2): begin
        sel     = SEL_AB;
        fin     = 1'b1;
        state_d = STATE_W'(S_FETCH);
      end
      default: state_d = STATE_W'(S_FETCH);
    endcase

    if (fin) begin
      if (is_store)                         rw = 1'b1;
      else if (bus.opcode_reg[7:5] == OP_CMP) pl = 1'b1;
      else                                  {al, pl} = 2'b11;
    end

    // A memory stall freezes the state and suppresses every register load.
    if (!bus.ready) begin
      state_d = state_q;
      {il, pc, dl, dh, al, pl} = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= STATE_W'(S_FETCH);
    else     state_q <= state_d;
  end

  always_comb begin
    bus.instruction_load = !rst && il;
    bus.increment_pc     = !rst && pc;
    bus.dirl_load        = !rst && dl;
    bus.dirh_load        = !rst && dh;
    bus.a_load           = !rst && al;
    bus.p_load           = !rst && pl;
    bus.read_write       = !rst && rw;
    bus.address_select   = rst ? SEL_PC : sel;
    bus.index_en         = !rst && ie;
    bus.index_select     = !rst && is;
    bus.alu_opcode       = (!rst && bus.opcode_reg[1:0] == 2'b01) ?
                           ALU_OP_W'(bus.opcode_reg[7:5]) : NOP_ALU_OP;
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Self-checking bench for control_unit_seq: an instruction-level model expands
// each opcode into its expected per-cycle strobe vectors, compared every cycle.
module tb_control_unit_seq;
`ifdef PAGE_CROSS_OPT_EN
  localparam bit OPT = 1'b1;
`else
  localparam bit OPT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ir = 8'h00;

  // Vector: il pc dirl dirh a p rw sel[1:0] ie is alu[2:0]
  logic [13:0] exp_q[$];
  logic [13:0] model_q[$];
  logic [13:0] act_tr[$];

  control_unit_seq_if #(.ALU_OP_W(3)) bus ();

  control_unit_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [13:0] act_vec();
    return {bus.instruction_load, bus.increment_pc, bus.dirl_load, bus.dirh_load,
            bus.a_load, bus.p_load, bus.read_write, bus.address_select,
            bus.index_en, bus.index_select, bus.alu_opcode};
  endfunction

  function automatic logic [2:0] alu_of(input logic [7:0] op);
    return (op[1:0] == 2'b01) ? op[7:5] : 3'b111;
  endfunction

  function automatic logic [13:0] mk(input bit il, input bit pc, input bit dl, input bit dh,
                                     input bit rw, input logic [1:0] sel,
                                     input bit ie, input bit is);
    return {il, pc, dl, dh, 1'b0, 1'b0, rw, sel, ie, is, 3'b000};
  endfunction

  // Operand cycle: stores write, CMP sets flags only, everything else loads A and flags.
  function automatic logic [13:0] fin_vec(input logic [7:0] op, input bit pc,
                                          input logic [1:0] sel, input bit ie, input bit is);
    logic [13:0] v;
    v = mk(0, pc, 0, 0, 0, sel, ie, is);
    if (op[7:5] == 3'd4)      v[7] = 1'b1;
    else if (op[7:5] == 3'd6) v[8] = 1'b1;
    else                      v[9:8] = 2'b11;
    return v;
  endfunction

  task automatic build_model(input logic [7:0] op, input bit carry);
    logic [2:0] bbb;
    bit         valid, isy;
    bbb   = op[4:2];
    valid = (op[1:0] == 2'b01) && (bbb != 3'b000) && (bbb != 3'b100) && (op != 8'h89);
    isy   = (bbb == 3'b110);
    model_q.delete();
    model_q.push_back(mk(1, 1, 0, 0, 0, 2'b00, 0, 0));
    if (valid) begin
      case (bbb)
        3'b010: model_q.push_back(fin_vec(op, 1, 2'b00, 0, 0));
        3'b001: begin
          model_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0));
          model_q.push_back(fin_vec(op, 0, 2'b01, 0, 0));
        end
        3'b101: begin
          model_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0));
          model_q.push_back(mk(0, 0, 0, 0, 0, 2'b01, 1, 0));
          model_q.push_back(fin_vec(op, 0, 2'b01, 1, 0));
        end
        3'b011: begin
          model_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0));
          model_q.push_back(mk(0, 1, 0, 1, 0, 2'b00, 0, 0));
          model_q.push_back(fin_vec(op, 0, 2'b10, 0, 0));
        end
        default: begin
          model_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0));
          model_q.push_back(mk(0, 1, 0, 1, 0, 2'b00, 0, 0));
          if (OPT && op[7:5] != 3'd4 && !carry)
            model_q.push_back(fin_vec(op, 0, 2'b10, 1, isy));
          else begin
            model_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 1, isy));
            model_q.push_back(fin_vec(op, 0, carry ? 2'b11 : 2'b10, 1, isy));
          end
        end
      endcase
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_instr(input logic [7:0] op, input bit carry,
                           input int stall_at, input int stall_n);
    build_model(op, carry);
    act_tr.delete();
    for (int i = 0; i < model_q.size(); i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.ready       = 1'b0;
          bus.opcode      = (i == 0) ? op : 8'($urandom_range(0, 255));
          bus.index_carry = carry;
          exp_q.push_back((model_q[i] & 14'h00FF) | {11'b0, alu_of(ir)});
          @(posedge clk); #1;
        end
      end
      bus.ready       = 1'b1;
      bus.opcode      = (i == 0) ? op : 8'($urandom_range(0, 255));
      bus.index_carry = carry;
      exp_q.push_back(model_q[i] | {11'b0, alu_of(ir)});
      @(posedge clk); #1;
      if (i == 0) begin
        ir             = op;
        bus.opcode_reg = ir;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e, a;
      e = exp_q.pop_front();
      a = act_vec();
      act_tr.push_back(a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_vec op=%02h: got %b expected %b", ir, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst              = 1'b1;
    bus.ready        = 1'b1;
    bus.opcode       = 8'h00;
    bus.opcode_reg   = 8'h00;
    bus.index_carry  = 1'b0;
    #3;
    check_lit("reset_outputs", int'(act_vec()), 32'h0007);
    @(posedge clk); #1;
    rst = 1'b0;

    // LDA #imm
    run_instr(8'hA9, 0, -1, 0);
    check_lit("lat_A9", act_tr.size(), 2);
    check_lit("A9_fetch_il", int'(act_tr[0][13]), 1);
    check_lit("A9_im0_ap", int'(act_tr[1][9:8]), 3);
    check_lit("A9_im0_alu", int'(act_tr[1][2:0]), 5);

    // ADC zp,X (carry must not matter)
    run_instr(8'h75, 0, -1, 0);
    check_lit("lat_75", act_tr.size(), 4);
    run_instr(8'h75, 1, -1, 0);
    check_lit("75_zp1_sel", int'(act_tr[3][6:5]), 1);
    check_lit("75_zp1_ie", int'(act_tr[3][4]), 1);
    check_lit("75_zpx_aload", int'(act_tr[2][9]), 0);

    // ADC abs,X without / with page cross
    run_instr(8'h7D, 0, -1, 0);
    check_lit("lat_7D_nc", act_tr.size(), OPT ? 4 : 5);
    run_instr(8'h7D, 1, -1, 0);
    check_lit("lat_7D_c", act_tr.size(), 5);
    check_lit("7D_fix_sel", int'(act_tr[4][6:5]), 3);

    // STA abs,Y
    run_instr(8'h99, 0, -1, 0);
    check_lit("lat_99", act_tr.size(), 5);
    check_lit("99_abx_rw", int'(act_tr[3][7]), 0);
    check_lit("99_fix_rw", int'(act_tr[4][7]), 1);
    check_lit("99_fix_isel", int'(act_tr[4][3]), 1);
    check_lit("99_fix_sel", int'(act_tr[4][6:5]), 2);
    check_lit("99_fix_aload", int'(act_tr[4][9]), 0);

    // LDA abs with a 3-cycle stall in AB1
    run_instr(8'hAD, 0, 2, 3);
    check_lit("lat_AD_stall", act_tr.size(), 7);
    check_lit("AD_stall0_dirh", int'(act_tr[2][10]), 0);
    check_lit("AD_stall2_dirh", int'(act_tr[4][10]), 0);
    check_lit("AD_resume_dirh", int'(act_tr[5][10]), 1);

    // Mixed ops and NOP forms
    run_instr(8'h05, 0, -1, 0);
    check_lit("lat_05", act_tr.size(), 3);
    run_instr(8'hC9, 0, -1, 0);
    check_lit("C9_p_only", int'(act_tr[1][9:8]), 1);
    run_instr(8'h89, 0, -1, 0);
    check_lit("lat_89", act_tr.size(), 1);
    run_instr(8'h61, 0, -1, 0);
    check_lit("lat_61", act_tr.size(), 1);
    run_instr(8'h19, 1, -1, 0);
    run_instr(8'hF9, 0, -1, 0);
    run_instr(8'h8D, 0, -1, 0);
    run_instr(8'h95, 0, -1, 0);
    run_instr(8'hE5, 0, -1, 0);
    run_instr(8'h5D, 1, -1, 0);

    // Asynchronous reset in ZP0 of LDA... (ADC zp)
    bus.ready  = 1'b1;
    bus.opcode = 8'h65;
    exp_q.push_back(mk(1, 1, 0, 0, 0, 2'b00, 0, 0) | {11'b0, alu_of(ir)});
    @(posedge clk); #1;
    ir             = 8'h65;
    bus.opcode_reg = ir;
    #1;
    check_lit("zp0_dirl_before_rst", int'(bus.dirl_load), 1);
    rst = 1'b1;
    #1;
    check_lit("rst_async_outputs", int'(act_vec()), 32'h0007);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(8'h02, 0, -1, 0);
    check_lit("post_rst_il", int'(act_tr[0][13]), 1);
    check_lit("lat_02", act_tr.size(), 1);
    run_instr(8'hA9, 0, -1, 0);

    @(posedge clk); #1;
    check_lit("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
